// File: rtl/imem_uart_loader_pkg.sv
// Shared encodings and constants for the UART instruction-memory loader.
package imem_uart_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_FULL
  } ld_state_t;

  localparam int          UART_DATA_BITS = 8;
  localparam logic [31:0] IMEM_NOP       = 32'h0000_0013;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port owned by the loader.
interface imem_uart_loader_if;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;

  modport master (output WE, output A, output WD);
  modport slave  (input  WE, input  A, input  WD);
endinterface

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop RX synchronizer, start-bit glitch rejection,
// mid-bit sampling with a down-counting bit timer.
//
// state    | meaning
// ---------+-----------------------------------------------
// RX_IDLE  | line idle, waiting for synced RX low
// RX_START | half-bit wait, confirm start bit still low
// RX_DATA  | sampling 8 data bits LSB first
// RX_STOP  | sampling stop bit; high = byte, low = framing error
module imem_uart_loader_uart_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err_pulse
);

  localparam int             TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  FULL_BIT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_meta_q, rx_sync_q;
  rx_state_t                 state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] byte_q, byte_d;
  logic                      byte_valid_q, byte_valid_d;
  logic                      ferr_q, ferr_d;

  // Next-state and datapath for the receive FSM.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          state_d = RX_START;
          timer_d = HALF_BIT;
        end
      end
      RX_START: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (!rx_sync_q) begin
          state_d   = RX_DATA;
          timer_d   = FULL_BIT;
          bit_idx_d = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d = {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
          timer_d = FULL_BIT;
          if (bit_idx_q == LAST_BIT) state_d = RX_STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchronizer and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= RX_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      ferr_q       <= ferr_d;
    end
  end

  assign byte_data       = byte_q;
  assign byte_valid      = byte_valid_q;
  assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// UART instruction-memory loader: packs little-endian bytes into 32-bit
// words and writes them to consecutive word addresses from 0.
// Optional checksum: define IMEM_LOADER_CSUM_EN to implement CSUM.
//
// state    | meaning
// ---------+-----------------------------------------------
// LD_IDLE  | no session; bytes ignored
// LD_RECV  | collecting bytes 0..3 of the next word
// LD_WRITE | single-cycle write pulse to instruction memory
// LD_FULL  | DEPTH words written; further bytes ignored
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 20
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      RX,
  input  logic                      LOAD_EN,
  imem_uart_loader_if.master        imem,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [4:0]                WORD_CNT,
  output logic                      FRAME_ERR,
  output logic [31:0]               CSUM
);

  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;

  imem_uart_loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk             (CLK),
    .rst_n           (RST_N),
    .rx              (RX),
    .byte_data       (rx_byte),
    .byte_valid      (rx_valid),
    .frame_err_pulse (rx_ferr)
  );

  ld_state_t   state_q, state_d;
  logic        load_en_q;
  logic        load_rise;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic        we_q, we_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  word_cnt_q, word_cnt_d;
  logic        ferr_q, ferr_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  assign load_rise = LOAD_EN && !load_en_q;

  // Loader FSM next state; the write cycle always completes even if
  // LOAD_EN drops during it.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    we_d       = 1'b0;
    a_d        = a_q;
    wd_d       = wd_q;
    busy_d     = busy_q;
    done_d     = done_q;
    word_cnt_d = word_cnt_q;
    ferr_d     = ferr_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif
    if (state_q == LD_WRITE) begin
      word_cnt_d = word_cnt_q + 5'd1;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d     = csum_q ^ wd_q;
`endif
      if (!LOAD_EN) begin
        state_d = LD_IDLE;
        busy_d  = 1'b0;
      end else if (word_cnt_d == DEPTH_CNT) begin
        state_d = LD_FULL;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = LD_RECV;
      end
    end else if (!LOAD_EN) begin
      state_d    = LD_IDLE;
      byte_idx_d = '0;
      busy_d     = 1'b0;
    end else if (load_rise) begin
      state_d    = LD_RECV;
      byte_idx_d = '0;
      word_cnt_d = '0;
      done_d     = 1'b0;
      ferr_d     = 1'b0;
      busy_d     = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d     = '0;
`endif
    end else if (state_q == LD_RECV && rx_valid) begin
      word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
      if (byte_idx_q == 2'd3) begin
        state_d    = LD_WRITE;
        we_d       = 1'b1;
        a_d        = {25'd0, word_cnt_q, 2'b00};
        wd_d       = word_d;
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end
    if (rx_ferr && LOAD_EN && !load_rise && state_q != LD_IDLE) ferr_d = 1'b1;
  end

  // Loader registers; reset kills any pending write pulse immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= LD_IDLE;
      load_en_q  <= 1'b0;
      byte_idx_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      a_q        <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
      ferr_q     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_en_q  <= LOAD_EN;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      we_q       <= we_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      word_cnt_q <= word_cnt_d;
      ferr_q     <= ferr_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem.WE   = we_q;
  assign imem.A    = a_q;
  assign imem.WD   = wd_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign WORD_CNT  = word_cnt_q;
  assign FRAME_ERR = ferr_q;
`ifdef IMEM_LOADER_CSUM_EN
  assign CSUM      = csum_q;
`else
  assign CSUM      = 32'h0;
`endif

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

UART-driven programmer that sits directly upstream of the instruction memory and owns its write port (WE, A, WD). It receives a little-endian byte stream over a single RX pin and packs it into 32-bit words. Each word is written to consecutive word addresses starting at 0, one write-enable pulse per word. While loading, it holds the core off through BUSY.

## Interface
Parameters:
- CLKS_PER_BIT, 434, CLK cycles per UART bit (50 MHz / 115200); minimum 4
- DEPTH, 20, instruction memory depth in words; loader never addresses beyond DEPTH-1

Ports:
- CLK  input  1  single clock, all logic on rising edge
- RST_N  input  1  asynchronous, active-low reset
- RX  input  1  UART line, 8N1, idle high, asynchronous to CLK
- LOAD_EN  input  1  level; high = programming session active
- WE  output  1  instruction memory write enable, one-cycle pulse per word
- A  output  32  byte address = word_index << 2
- WD  output  32  write data
- BUSY  output  1  high while LOAD_EN high and not DONE; gates core reset in top level
- DONE  output  1  DEPTH words written in current session
- WORD_CNT  output  5  words written in current session
- FRAME_ERR  output  1  sticky; a stop bit was sampled low this session
- CSUM  output  32  XOR of all words written this session (see Configuration)

## Operation
- RX passes through a 2-flop synchronizer before any use.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START: on synced RX low.
  - START, after CLKS_PER_BIT/2 cycles:
    - RX still low -> DATA.
    - RX high -> IDLE. This is a glitch; no byte is produced.
  - DATA: samples 8 bits LSB first, one every CLKS_PER_BIT cycles. After bit 7 -> STOP.
  - STOP, after CLKS_PER_BIT cycles:
    - RX high -> one-cycle byte_valid.
    - RX low -> byte discarded and FRAME_ERR set.
    - Either way -> IDLE.
- Loader FSM, states IDLE, RECV, WRITE, FULL:
  - LOAD_EN rising edge: clears byte index, WORD_CNT, DONE, FRAME_ERR and CSUM, then -> RECV.
  - RECV, on byte_valid: byte k (0..3) goes into word bits [8k+7:8k]. After byte 3 -> WRITE.
  - WRITE: lasts exactly one cycle with WE=1, A=WORD_CNT<<2, WD=assembled word. WORD_CNT increments and CSUM ^= WD on the same edge.
    - If the new WORD_CNT equals DEPTH -> FULL.
    - Otherwise -> RECV.
  - FULL: DONE=1, BUSY=0. All further bytes are ignored and WE is never asserted.
  - LOAD_EN low in any state -> IDLE:
    - A partial word is discarded and the byte index is cleared.
    - WORD_CNT, DONE, CSUM and FRAME_ERR hold their values.
    - Bytes are ignored in IDLE.
- A and WD hold their last written values between pulses.

## Timing
- Reset values:
  - WE=0, A=0, WD=0, BUSY=0, DONE=0, WORD_CNT=0, FRAME_ERR=0, CSUM=0.
  - Both FSMs in IDLE; synchronizer flops = 1.
- Reset is honoured at any point, including mid-byte or in the WRITE cycle; no WE pulse is emitted after reset assertion.
- Synchronizer adds 2 cycles of RX latency.
- byte_valid occurs 1 cycle after the stop-bit sample.
- WE is asserted on the cycle after byte_valid of byte 3; the memory captures the word on that cycle's rising edge.
- BUSY and DONE are registered and update on the edge that leaves WRITE.
- LOAD_EN falling in the same cycle as byte_valid: the byte is dropped.
- LOAD_EN falling in the WRITE cycle: the write completes and the FSM then goes to IDLE.
- WORD_CNT never exceeds DEPTH, and the address never wraps.

## Configuration
- IMEM_LOADER_CSUM_EN:
  - Defined: CSUM register implemented as described.
  - Undefined: CSUM tied to 32'h0 and no XOR logic is synthesized; all other behaviour is unchanged.

## Structure
- Shared package holds:
  - The RX FSM state encoding.
  - The loader FSM state encoding.
  - The UART frame constant (8 data bits).
  - The NOP constant 32'h00000013 used by the memory.
- One sub-module: uart_rx. It contains the synchronizer and RX FSM, has parameter CLKS_PER_BIT, and has outputs byte[7:0], byte_valid and frame_err_pulse. The loader FSM stays in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Single word: LOAD_EN=1, send 0x13,0x00,0x00,0x00 -> one WE pulse with A=0, WD=32'h00000013; WORD_CNT=1; BUSY=1.
- Full load: send 80 bytes (word i = i) -> 20 WE pulses at A=0x00..0x4C; DONE=1 and BUSY=0 after the 20th. Then send 4 more bytes -> no WE; WORD_CNT=20.
- Framing error: send 0xAA with stop bit low -> no byte stored; FRAME_ERR=1. Next 4 good bytes -> correct word written at A=0.
- Abort: send 2 bytes, drop LOAD_EN, raise it again, send 0x11,0x22,0x33,0x44 -> WD=32'h44332211 at A=0; WORD_CNT=1.
- Glitch and reset:
  - RX low for 1 cycle -> no byte produced.
  - RST_N low midway through byte 3 -> all outputs return to reset values; no WE pulse.
- Checksum (macro defined): write 32'h0000FFFF then 32'hFFFF0000 -> CSUM=32'hFFFFFFFF. With the macro undefined -> CSUM=0.
